seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Parametrised, time-multiplexed driver for a bank of common-anode seven-segment digits. It replaces one-decoder-per-digit wiring with a single shared decoder that scans `DIGITS` digits in a fixed order. It adds hex/BCD mode, per-digit decimal point and blanking, leading-zero suppression, anti-ghosting blank gaps, and double-buffered input loading. It sits between the datapath/debug logic and the board's segment/anode pins.

## Interface
- `DIGITS`, default 8: number of digits scanned; at least 2.
- `DRIVE_CYC`, default 1000: clock cycles each digit is driven; at least 1.
- `BLANK_CYC`, default 16: all-anodes-off cycles before each digit; at least 1.
- `clk` input 1: single system clock; all state on rising edge.
- `rst_n` input 1: **reset is asynchronous and active-low**; one clock domain only.
- `en` input 1: scan enable; 0 forces the display dark.
- `load` input 1: one-cycle strobe that latches `val`, `dp`, `blank`, `hex_mode`, `lz_en` into shadow registers.
- `val` input 4*DIGITS: nibble i = digit i; digit 0 is rightmost.
- `dp` input DIGITS: decimal point on for digit i.
- `blank` input DIGITS: force digit i dark.
- `hex_mode` input 1: 1 = hex 0–F, 0 = BCD.
- `lz_en` input 1: enable leading-zero suppression.
- `seg` output 8: active-low; bit 7 = dp, bits 6..0 = a,b,c,d,e,f,g.
- `an` output DIGITS: active-low anode select; at most one bit low at a time.
- `frame_tick` output 1: one-cycle pulse at the end of each full scan.
- `err` output 1: the last load contained an invalid BCD nibble.

## Operation
- **States:** `OFF`, `GAP`, `DRIVE`. A cycle counter and a digit index `idx` (0..DIGITS-1) control the scan.
- **After reset:** state `GAP`, `idx`=0, counter 0, shadows all 0.
- **GAP:** `an` all 1, `seg`=8'hFF for BLANK_CYC cycles, then go to `DRIVE`.
- **DRIVE:** `an[idx]`=0 for DRIVE_CYC cycles, then go to `GAP`.
  - `idx` increments when DRIVE ends and wraps from DIGITS-1 to 0.
  - The wrap cycle pulses `frame_tick`.
- **en=0:** go to `OFF` in the next cycle, with outputs dark, `idx`=0 and counter cleared. When `en` returns to 1, go to `GAP` and start again at digit 0.
- **Segment decode**, with seg[6:0] active-low:
  - Digits 0–9 use the standard encoding, e.g. 0=7'b0000001, 1=7'b1001111, 4=7'b1001100, 7=7'b0001111, 8=7'b0000000.
  - Hex A–F: A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - In BCD mode, a nibble above 9 shows a dash, 7'b1111110.
  - seg[7] = ~dp[idx].
- **Blanking:** a digit is dark (seg=8'hFF) when `blank[idx]` is set, or when it is suppressed.
  - The `an` timing for a dark digit is unchanged, so it still takes its slot with `an[idx]` low.
  - A dark digit drives `seg`=8'hFF, and its dp bit is also off.
- **Leading-zero suppression (lz_en=1):** digit i>0 is suppressed when every nibble i..DIGITS-1 is 0 and not blank-forced. Digit 0 is never suppressed.
- **Double buffering:** `load` writes the shadows on the next edge. The displayed digit samples the shadows only on entry to `DRIVE`, so a load never changes a digit while it is lit.
- **err:** updated on each `load`.
  - Set to 1 when hex_mode=0 and any loaded nibble exceeds 9; otherwise set to 0.
  - Holds its value between loads.
- **Simultaneous events:**
  - `load` together with `en` falling: the load is still taken.
  - `rst_n` low wins over everything.

## Timing
- `seg`, `an` and `frame_tick` are registered. The reset values are `seg`=8'hFF, `an`=all 1, `frame_tick`=0, `err`=0, and they apply asynchronously while `rst_n`=0.
- The frame period is DIGITS*(BLANK_CYC+DRIVE_CYC) cycles.
- The first lit digit appears BLANK_CYC cycles after the first edge with `rst_n`=1.
- Latency from `load` to the display: the new value shows at the next `DRIVE` entry, worst case BLANK_CYC+DRIVE_CYC+1 cycles.
- Changing `en` affects the outputs at the next edge.

## Structure
- **Package `seg7_pkg`:**
  - Segment pattern constants for 0–F.
  - `SEG_OFF`=8'hFF and `SEG_DASH`=8'b1111_1110.
  - The state enum {OFF, GAP, DRIVE}.
- **Sub-module `seg7_decode`:** purely combinational. Inputs are the nibble, `hex_mode`, `dp` and `dark`; the output is 8-bit `seg`. One instance, shared across all digits.
- **Top level:** the FSM, counters, shadows and leading-zero logic, in roughly 150–250 lines of RTL.

## Test plan
Bench parameters: DIGITS=4, DRIVE_CYC=4, BLANK_CYC=2.
1. **Reset:** assert `rst_n`=0 in the middle of a DRIVE → `seg`=8'hFF and `an`=4'hF immediately. After release, 2 dark cycles, then `an`=4'b1110.
2. **Hex scan:** load `val`=16'h1234 with hex_mode=0 → digit0 `seg`=8'b1100_1100, digit3 `seg`=8'b1100_1111. `frame_tick` pulses every 24 cycles, and `an` is never low on two bits at once.
3. **Leading-zero suppression:** load `val`=16'h0070 with lz_en=1 → digits 3 and 2 give `seg`=8'hFF with `an` still cycling, digit1 gives 8'b1000_1111, digit0 gives 8'b1000_0001. With lz_en=0, digit3 shows 8'b1000_0001.
4. **BCD error:** load `val`=16'h00A5 with hex_mode=0 → digit1 `seg`=8'b1111_1110 and `err`=1. A following load of 16'h0012 clears `err` to 0.
5. **Load mid-digit:** load during the DRIVE of digit 1 → `seg` is unchanged for the rest of that slot, and the new value appears from the next DRIVE entry. With `dp`=4'b0001, digit0 shows seg[7]=0.
6. **Enable:** drop `en` in the middle of a frame → dark from the next cycle. When `en` returns to 1, the scan restarts at digit 0 after 2 gap cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the seven-segment scan driver.
//   - Glyph table for nibbles 0..F (active-low, bit order a,b,c,d,e,f,g)
//   - SEG_OFF / SEG_DASH full-byte patterns (bit 7 = dp, active-low)
//   - Scan FSM state enum
package seg7_pkg;

  // Index n holds the pattern for nibble n; segment a is bit 6, g is bit 0.
  localparam logic [15:0][6:0] GLYPHS = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [7:0] SEG_DASH = 8'b1111_1110;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_GAP   = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational nibble-to-segment decoder, shared by all digits.
// Ports:
//   nib      - 4-bit digit value
//   hex_mode - 1: show 0..F, 0: BCD (values above 9 show a dash)
//   dp       - decimal point request (active-high)
//   dark     - force the whole digit off, including the decimal point
//   seg      - active-low segments, bit 7 = dp, bits 6..0 = a..g
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       hex_mode,
  input  logic       dp,
  input  logic       dark,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (!dark) begin
      if (!hex_mode && (nib > 4'd9)) begin
        seg = {~dp, SEG_DASH[6:0]};
      end else begin
        seg = {~dp, GLYPHS[nib]};
      end
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for DIGITS common-anode
// seven-segment digits through one shared decoder.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   en          - scan enable; 0 darkens the display and parks the scan
//   load        - strobe latching val/dp/blank/hex_mode/lz_en into shadows
//   val         - nibble i drives digit i (digit 0 rightmost)
//   dp, blank   - per-digit decimal point and forced blanking
//   hex_mode    - 1: hex glyphs, 0: BCD with dash for invalid nibbles
//   lz_en       - leading-zero suppression enable
//   seg         - active-low segments (bit 7 = dp)
//   an          - active-low anode select, at most one bit low
//   frame_tick  - one-cycle pulse with the last driven cycle of each frame
//   err         - last load carried an invalid BCD nibble
// Outputs are registered from the current scan state, so they trail the
// FSM by one cycle; en=0 overrides that and darkens at the very next edge.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned DRIVE_CYC = 1000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   val,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  hex_mode,
  input  logic                  lz_en,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick,
  output logic                  err
);

  localparam int IDX_W   = $clog2(DIGITS);
  localparam int CNT_MAX = (DRIVE_CYC > BLANK_CYC) ? DRIVE_CYC : BLANK_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  scan_state_e          state;
  logic [IDX_W-1:0]     idx;
  logic [CNT_W-1:0]     cnt;

  logic [4*DIGITS-1:0]  sh_val;
  logic [DIGITS-1:0]    sh_dp;
  logic [DIGITS-1:0]    sh_blank;
  logic                 sh_hex;
  logic                 sh_lz;

  logic [DIGITS-1:0]    lz_sup;
  logic                 lz_run;
  logic                 bcd_bad;

  logic                 gap_done;
  logic                 drive_done;
  logic                 last_digit;
  logic                 enter_drive;

  logic [3:0]           nib_p0;
  logic                 hex_p0;
  logic                 dp_p0;
  logic                 dark_p0;
  logic [7:0]           dec_seg;

  logic [7:0]           seg_nxt;
  logic [DIGITS-1:0]    an_nxt;
  logic                 tick_nxt;

  // Any invalid BCD nibble in the incoming word (judged at load time).
  always_comb begin
    bcd_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_bad = bcd_bad | (val[4*i +: 4] > 4'd9);
    end
  end

  // Leading-zero suppression: walk from the most significant digit down,
  // a digit is suppressed while every nibble from it upward is zero.
  // Digit 0 always stays visible so a zero value still shows "0".
  always_comb begin
    lz_sup = '0;
    lz_run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_run = lz_run & (sh_val[4*i +: 4] == 4'd0);
      if (i > 0) begin
        lz_sup[i] = sh_lz & lz_run;
      end
    end
  end

  assign gap_done    = (cnt == CNT_W'(BLANK_CYC - 1));
  assign drive_done  = (cnt == CNT_W'(DRIVE_CYC - 1));
  assign last_digit  = (idx == IDX_W'(DIGITS - 1));
  assign enter_drive = en && (state == ST_GAP) && gap_done;

  // Shadow registers and error flag; load is honoured regardless of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_val   <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
      sh_hex   <= 1'b0;
      sh_lz    <= 1'b0;
      err      <= 1'b0;
    end else if (load) begin
      sh_val   <= val;
      sh_dp    <= dp;
      sh_blank <= blank;
      sh_hex   <= hex_mode;
      sh_lz    <= lz_en;
      err      <= ~hex_mode & bcd_bad;
    end
  end

  // Scan FSM: GAP (all anodes off) then DRIVE (one anode on), per digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_GAP;
      idx   <= '0;
      cnt   <= '0;
    end else if (!en) begin
      state <= ST_OFF;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_OFF: begin
          state <= ST_GAP;
          idx   <= '0;
          cnt   <= '0;
        end
        ST_GAP: begin
          if (gap_done) begin
            state <= ST_DRIVE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (drive_done) begin
            state <= ST_GAP;
            cnt   <= '0;
            idx   <= last_digit ? '0 : idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_GAP;
          idx   <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // ---- p0: digit contents frozen on DRIVE entry (loads cannot disturb a lit digit)
  always_ff @(posedge clk) begin
    if (enter_drive) begin
      nib_p0  <= sh_val[{idx, 2'b00} +: 4];
      hex_p0  <= sh_hex;
      dp_p0   <= sh_dp[idx];
      dark_p0 <= sh_blank[idx] | lz_sup[idx];
    end
  end

  seg7_decode u_decode (
    .nib      (nib_p0),
    .hex_mode (hex_p0),
    .dp       (dp_p0),
    .dark     (dark_p0),
    .seg      (dec_seg)
  );

  always_comb begin
    seg_nxt  = SEG_OFF;
    an_nxt   = '1;
    tick_nxt = 1'b0;
    if (en && (state == ST_DRIVE)) begin
      seg_nxt  = dec_seg;
      an_nxt   = ~(DIGITS'(1) << idx);
      tick_nxt = drive_done && last_digit;
    end
  end

  // ---- output registers (pin-facing)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_OFF;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_nxt;
      an         <= an_nxt;
      frame_tick <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: self-checking bench for seg7_scan_driver with
// DIGITS=4, DRIVE_CYC=4, BLANK_CYC=2. Expected outputs come from a cycle-
// position model: m counts cycles since the scan (re)started, each digit
// owns a slot of BLANK+DRIVE cycles, the first BLANK of which are dark.
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int DRV   = 4;
  localparam int BLK   = 2;
  localparam int SLOT  = BLK + DRV;
  localparam int FRAME = N * SLOT;

  logic        clk = 1'b0;
  logic        rst_n, en, load, hex_mode, lz_en;
  logic [15:0] val;
  logic [3:0]  dp, blank;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tick, err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        hex;
    logic        lz;
  } cfg_t;

  cfg_t cur;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(N), .DRIVE_CYC(DRV), .BLANK_CYC(BLK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .val        (val),
    .dp         (dp),
    .blank      (blank),
    .hex_mode   (hex_mode),
    .lz_en      (lz_en),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick),
    .err        (err)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic [7:0] digit_seg(input cfg_t c, input int d);
    logic [15:0] upper;
    logic [3:0]  nib;
    logic        dark;
    upper = c.val >> (4 * d);
    nib   = upper[3:0];
    dark  = c.blank[d] || (c.lz && (d > 0) && (upper == 16'h0));
    if (dark) return 8'hFF;
    if (!c.hex && (nib > 4'd9)) return {~c.dp[d], 7'b1111110};
    return {~c.dp[d], glyph(nib)};
  endfunction

  // {seg, an, frame_tick} expected m cycles into a scan.
  function automatic logic [12:0] expect_out(input cfg_t c, input int m);
    int   d;
    int   p;
    logic t;
    d = (m / SLOT) % N;
    p = m % SLOT;
    t = ((m % FRAME) == FRAME - 1);
    if (p < BLK) return {8'hFF, 4'hF, t};
    return {digit_seg(c, d), ~(4'b0001 << d), t};
  endfunction

  function automatic logic bcd_bad(input cfg_t c);
    logic b;
    b = 1'b0;
    for (int i = 0; i < N; i++) b = b | (((c.val >> (4 * i)) & 16'hF) > 16'd9);
    return !c.hex && b;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input cfg_t c);
    val = c.val; dp = c.dp; blank = c.blank; hex_mode = c.hex; lz_en = c.lz;
    load = 1'b1;
    step();
    load = 1'b0;
    cur = c;
  endtask

  // Leaves the bench at the negedge right after the OFF->GAP edge.
  task automatic restart();
    en = 1'b0;
    step();
    en = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [12:0] e;
    do_load('{val: 16'h00A5, dp: 4'b0, blank: 4'b0, hex: 1'b0, lz: 1'b0});
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL reset_pre_err got %b want 1", err); end
    restart();
    for (int m = 0; m < 5; m++) step();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({seg, an, frame_tick, err} !== {8'hFF, 4'hF, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_async got seg=%h an=%b tick=%b err=%b want FF 1111 0 0", seg, an, frame_tick, err);
    end
    step();
    rst_n = 1'b1;
    cur = '0;
    for (int m = 0; m < FRAME; m++) begin
      step();
      e = expect_out(cur, m);
      n_cmp++;
      if ({seg, an, frame_tick} !== e) begin
        n_bad++;
        $display("FAIL reset_scan m=%0d got seg=%b an=%b tick=%b want %b", m, seg, an, frame_tick, e);
      end
      if (m == 2) begin
        n_cmp++;
        if (an !== 4'b1110) begin n_bad++; $display("FAIL reset_first_lit got an=%b want 1110", an); end
      end
    end
  endtask

  task automatic test_hex_scan();
    logic [12:0] e;
    do_load('{val: 16'h1234, dp: 4'b0, blank: 4'b0, hex: 1'b0, lz: 1'b0});
    restart();
    for (int m = 0; m < 2 * FRAME; m++) begin
      step();
      e = expect_out(cur, m);
      n_cmp++;
      if ({seg, an, frame_tick} !== e) begin
        n_bad++;
        $display("FAIL hex_scan m=%0d got seg=%b an=%b tick=%b want %b", m, seg, an, frame_tick, e);
      end
      n_cmp++;
      if ($countones(~an) > 1) begin
        n_bad++;
        $display("FAIL anode_onehot m=%0d got an=%b want at most one low", m, an);
      end
      if (m == 2) begin
        n_cmp++;
        if (seg !== 8'b1100_1100) begin n_bad++; $display("FAIL hex_digit0 got %b want 11001100", seg); end
      end
      if (m == 3 * SLOT + 2) begin
        n_cmp++;
        if (seg !== 8'b1100_1111) begin n_bad++; $display("FAIL hex_digit3 got %b want 11001111", seg); end
      end
    end
  endtask

  task automatic test_lz();
    logic [12:0] e;
    for (int pass = 0; pass < 2; pass++) begin
      do_load('{val: 16'h0070, dp: 4'b0, blank: 4'b0, hex: 1'b0, lz: (pass == 0)});
      restart();
      for (int m = 0; m < FRAME; m++) begin
        step();
        e = expect_out(cur, m);
        n_cmp++;
        if ({seg, an, frame_tick} !== e) begin
          n_bad++;
          $display("FAIL lz pass=%0d m=%0d got seg=%b an=%b tick=%b want %b", pass, m, seg, an, frame_tick, e);
        end
      end
    end
  endtask

  task automatic test_bcd_err();
    logic [12:0] e;
    do_load('{val: 16'h00A5, dp: 4'b0, blank: 4'b0, hex: 1'b0, lz: 1'b0});
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL bcd_err_set got %b want 1", err); end
    restart();
    for (int m = 0; m < FRAME; m++) begin
      step();
      e = expect_out(cur, m);
      n_cmp++;
      if ({seg, an, frame_tick, err} !== {e, 1'b1}) begin
        n_bad++;
        $display("FAIL bcd_scan m=%0d got seg=%b an=%b tick=%b err=%b want %b err=1", m, seg, an, frame_tick, err, e);
      end
    end
    do_load('{val: 16'h0012, dp: 4'b0, blank: 4'b0, hex: 1'b0, lz: 1'b0});
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL bcd_err_clear got %b want 0", err); end
  endtask

  task automatic test_load_mid();
    cfg_t        a, b;
    logic [12:0] e;
    a = '{val: 16'h1234, dp: 4'b0001, blank: 4'b0, hex: 1'b0, lz: 1'b0};
    b = '{val: 16'h9876, dp: 4'b0001, blank: 4'b0, hex: 1'b0, lz: 1'b0};
    do_load(a);
    restart();
    for (int m = 0; m < FRAME + SLOT; m++) begin
      step();
      e = expect_out((m < 2 * SLOT) ? a : b, m);
      n_cmp++;
      if ({seg, an, frame_tick} !== e) begin
        n_bad++;
        $display("FAIL load_mid m=%0d got seg=%b an=%b tick=%b want %b", m, seg, an, frame_tick, e);
      end
      if (m == 9) begin
        val = b.val; dp = b.dp; blank = b.blank; hex_mode = b.hex; lz_en = b.lz;
        load = 1'b1;
      end
      if (m == 10) begin
        load = 1'b0;
        cur = b;
      end
    end
  endtask

  task automatic test_enable();
    logic [12:0] e;
    do_load('{val: 16'hBEEF, dp: 4'b0101, blank: 4'b0, hex: 1'b1, lz: 1'b0});
    restart();
    for (int m = 0; m < 10; m++) begin
      step();
      e = expect_out(cur, m);
      n_cmp++;
      if ({seg, an, frame_tick} !== e) begin
        n_bad++;
        $display("FAIL en_pre m=%0d got seg=%b an=%b tick=%b want %b", m, seg, an, frame_tick, e);
      end
    end
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if ({seg, an, frame_tick} !== {8'hFF, 4'hF, 1'b0}) begin
        n_bad++;
        $display("FAIL en_off k=%0d got seg=%b an=%b tick=%b want FF 1111 0", k, seg, an, frame_tick);
      end
    end
    en = 1'b1;
    step();
    n_cmp++;
    if ({seg, an} !== {8'hFF, 4'hF}) begin
      n_bad++;
      $display("FAIL en_resume got seg=%b an=%b want FF 1111", seg, an);
    end
    for (int m = 0; m < FRAME; m++) begin
      step();
      e = expect_out(cur, m);
      n_cmp++;
      if ({seg, an, frame_tick} !== e) begin
        n_bad++;
        $display("FAIL en_post m=%0d got seg=%b an=%b tick=%b want %b", m, seg, an, frame_tick, e);
      end
    end
  endtask

  task automatic test_random();
    cfg_t        c;
    logic [12:0] e;
    for (int it = 0; it < 10; it++) begin
      c.val   = 16'($urandom);
      c.dp    = 4'($urandom);
      c.hex   = 1'($urandom);
      c.lz    = 1'($urandom);
      c.blank = c.lz ? 4'b0 : 4'($urandom);
      if ((it % 3) == 0) c.val = c.val >> (4 * $urandom_range(1, 3));
      do_load(c);
      n_cmp++;
      if (err !== bcd_bad(c)) begin
        n_bad++;
        $display("FAIL rand_err it=%0d got %b want %b", it, err, bcd_bad(c));
      end
      restart();
      for (int m = 0; m < FRAME; m++) begin
        step();
        e = expect_out(cur, m);
        n_cmp++;
        if ({seg, an, frame_tick} !== e) begin
          n_bad++;
          $display("FAIL rand it=%0d val=%h m=%0d got seg=%b an=%b tick=%b want %b", it, c.val, m, seg, an, frame_tick, e);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; load = 1'b0;
    val = '0; dp = '0; blank = '0; hex_mode = 1'b0; lz_en = 1'b0;
    cur = '0;
    step();
    step();
    rst_n = 1'b1;
    test_reset();
    test_hex_scan();
    test_lz();
    test_bcd_err();
    test_load_mid();
    test_enable();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
